// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB first, one bit per cycle with hold low.
// Optional even-parity trailer cycle enabled by defining PISO_PARITY_EN.
module piso_serializer #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             hold,
   output logic             sout,
   output logic             sout_en,
   output logic             sout_par,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StParity,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CntW-1:0]  cnt_q;
`ifdef PISO_PARITY_EN
   logic             par_q;
`endif

   // Transfer FSM: load, shift MSB first (frozen while hold), optional parity, done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (load_valid) begin
                  shreg_q <= load_data;
                  cnt_q   <= '0;
`ifdef PISO_PARITY_EN
                  par_q   <= ^load_data;
`endif
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (!hold) begin
                  // Zero fill leaves shreg_q clear once the word is out, so sout idles at 0.
                  shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                  cnt_q   <= cnt_q + CntW'(1);
                  if (cnt_q == CntLast) begin
`ifdef PISO_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StDone;
`endif
                  end
               end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
               if (!hold) begin
                  state_q <= StDone;
               end
            end
`endif
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Outputs decode from registered state; hold only gates the enable strobes.
   always_comb begin
      load_ready = (state_q == StIdle);
      busy       = (state_q != StIdle);
      done       = (state_q == StDone);
      sout_en    = (state_q == StShift) && !hold;
      sout       = shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
      sout_par   = (state_q == StParity) && !hold;
      if (state_q == StParity) begin
         sout = par_q;
      end
`else
      sout_par   = 1'b0;
`endif
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter for the 128-bit serial-in capture shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per enabled clock.
- Drives `sout`/`sout_en` directly into the capture register's `in`/`en`. After WIDTH enabled bits, the capture register's parallel output equals the loaded word exactly.

Parameters:
- WIDTH, 128, word length in bits; must be >= 2. The bit counter is $clog2(WIDTH) bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  `load_data` is valid
- load_ready  output  1  serializer can accept a word (IDLE only)
- load_data  input  WIDTH  parallel word to transmit
- hold  input  1  pause shifting while high
- sout  output  1  serial data bit, equal to `shreg[WIDTH-1]`
- sout_en  output  1  `sout` is valid this cycle; the receiver samples on the next rising edge
- sout_par  output  1  parity bit cycle flag (tied to 0 unless PISO_PARITY_EN is defined)
- busy  output  1  transfer in progress (SHIFT, PARITY or DONE)
- done  output  1  one-cycle pulse after the transfer completes

Behaviour:
- Reset (async, takes effect immediately):
  - State: state=IDLE, shreg=0, cnt=0, par=0.
  - Outputs: sout=0, sout_en=0, sout_par=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT, PARITY (macro only), DONE. All outputs decode from registered state, so there are no combinational input-to-output paths except through `hold` on `sout_en`/`sout_par`.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1: shreg<=load_data, cnt<=0, par<=^load_data, state<=SHIFT.
  - `hold` is ignored in IDLE.
- SHIFT:
  - Outputs: busy=1, load_ready=0, sout=shreg[WIDTH-1], sout_en=!hold.
  - On an edge with hold=0: shreg<=shreg<<1 (zero fill), cnt<=cnt+1.
  - On the edge where hold=0 and cnt==WIDTH-1: state<=PARITY if the macro is defined, else DONE.
  - With hold=1: shreg, cnt and state are frozen and sout keeps its value.
- DONE:
  - Outputs: done=1, busy=1, load_ready=0, sout_en=0; lasts exactly one cycle, then state<=IDLE.
  - `load_valid` is ignored here; load_ready returns to 1 the following cycle.
- Latency: for a word accepted at edge E0 with no hold:
  - Bit WIDTH-1-k is presented between E(k) and E(k+1).
  - The receiver holds the full word after E(WIDTH).
  - done is high between E(WIDTH) and E(WIDTH+1); load_ready is 1 again after E(WIDTH+1).
  - Back-to-back throughput is one word per WIDTH+2 cycles (WIDTH+3 with parity).
- Boundaries:
  - load_valid while busy: not accepted, no effect.
  - `hold` asserted on the final bit: the transfer stays in SHIFT, sout_en=0, until hold drops.
  - Reset mid-transfer: aborts immediately to the reset values; the receiver holds a partial word.
  - `cnt` never wraps: it is cleared on load and the transfer ends at WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, the block enters PARITY for one enabled cycle with sout=par (even parity: XOR of the word), sout_par=!hold and sout_en=0.
  - PARITY honours `hold` exactly as SHIFT does; on an edge with hold=0 it moves to DONE.
  - Because sout_en=0 during PARITY, the capture register is not disturbed.
- Undefined: no PARITY state, sout_par is constant 0, and the `par` register is omitted.

Test Plan:
- Reset, then load 128'h0123456789ABCDEF_FEDCBA9876543210 with no hold -> exactly 128 cycles with sout_en=1, MSB first (first bit 0). A capture register fed by sout/sout_en reads the same value; done pulses once at cycle 129 after accept.
- Load 128'h1 and assert hold for 5 cycles at bit index 64 and for 3 cycles on the final bit -> sout_en=0 and sout stable during holds; 128 enabled bits total; capture register=128'h1; done 8 cycles later than the no-hold case.
- Assert load_valid continuously with two words A=all-ones, B=128'hAAAA...AAAA -> A accepted at E0, B accepted one cycle after done. load_ready=0 for 129 cycles between, and the captured words are A then B.
- Assert rst at bit 40 of a transfer -> all outputs at reset values in the same cycle; load_ready=1; a new load afterwards transmits cleanly.
- PISO_PARITY_EN defined, load 128'h7 (three ones) -> after 128 data bits, one cycle with sout_par=1, sout=1, sout_en=0; then done. Repeat with 128'h3 -> parity bit sout=0.
